// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one RV32I load/store, drives a word-wide memory and
// returns extended load data. Sub-word stores use read-modify-write (no byte enables).
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] rdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_t;

    localparam logic [31:0] MEM_WORDS_C = 32'(MEM_WORDS);

    state_t      state_r;
    logic        write_r;
    logic [2:0]  funct3_r;
    logic [1:0]  lane_r;
    logic [31:0] wdata_r;
    logic [31:0] loadValue_s;
    logic [31:0] mergedWord_s;

    function automatic logic reqError(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        logic bad;
        bad = 1'b0;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = a[0];
            3'b010:  bad = (a[1:0] != 2'b00);
            3'b100:  bad = wr;
            3'b101:  bad = wr | a[0];
            default: bad = 1'b1;
        endcase
        return bad | ({2'b00, a[31:2]} >= MEM_WORDS_C);
    endfunction

    function automatic logic [31:0] loadExtend(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
        logic [31:0] byteSh;
        logic [31:0] halfSh;
        logic [31:0] res;
        byteSh = word >> {lane, 3'b000};
        halfSh = word >> {lane[1], 4'b0000};
        case (f3)
            3'b000:  res = {{24{byteSh[7]}}, byteSh[7:0]};
            3'b100:  res = {24'h00_0000, byteSh[7:0]};
            3'b001:  res = {{16{halfSh[15]}}, halfSh[15:0]};
            3'b101:  res = {16'h0000, halfSh[15:0]};
            3'b010:  res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Replace only the addressed byte/half lane of the captured word.
    function automatic logic [31:0] storeMerge(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] mask;
        logic [31:0] data;
        case (f3)
            3'b000: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                data = {4{wd[7:0]}};
            end
            3'b001: begin
                mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                data = {2{wd[15:0]}};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wd;
            end
        endcase
        return (word & ~mask) | (data & mask);
    endfunction

    assign loadValue_s  = loadExtend(funct3_r, lane_r, memReadData);
    assign mergedWord_s = storeMerge(funct3_r, lane_r, memReadData, wdata_r);

    // Request FSM; every output is a register so memory-side signals stay glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            write_r      <= 1'b0;
            funct3_r     <= 3'b000;
            lane_r       <= 2'b00;
            wdata_r      <= 32'h0000_0000;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            rdata        <= 32'h0000_0000;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            memAddress   <= 32'h0000_0000;
            memWriteData <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        write_r      <= req_write;
                        funct3_r     <= funct3;
                        lane_r       <= addr[1:0];
                        wdata_r      <= wdata;
                        memAddress   <= {2'b00, addr[31:2]};
                        memWriteData <= wdata;
                        req_ready    <= 1'b0;
                        if (reqError(req_write, funct3, addr)) begin
                            state_r    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            rdata      <= 32'h0000_0000;
                        end else if (req_write && (funct3 == 3'b010)) begin
                            state_r  <= WRITE;
                            MemWrite <= 1'b1;
                        end else begin
                            state_r <= READ;
                            MemRead <= 1'b1;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                READ: begin
                    MemRead <= 1'b0;
                    if (write_r) begin
                        state_r      <= WRITE;
                        MemWrite     <= 1'b1;
                        memWriteData <= mergedWord_s;
                    end else begin
                        state_r    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        rdata      <= loadValue_s;
                    end
                end
                WRITE: begin
                    MemWrite   <= 1'b0;
                    state_r    <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    rdata      <= 32'h0000_0000;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state_r    <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    MemRead    <= 1'b0;
                    MemWrite   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: fixed vectors plus randomized requests against a
// byte-level memory model kept in the bench.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        resp_valid, resp_err;
    logic [31:0] rdata;
    logic        MemRead, MemWrite;
    logic [31:0] memAddress, memWriteData, memReadData;

    logic [31:0] tbMem [0:31];
    logic [31:0] model [0:31];
    logic        bdEn = 1'b0;
    logic [4:0]  bdIdx = 5'd0;
    logic [31:0] bdData = 32'h0;
    int          overlapCount = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .funct3(funct3), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .rdata(rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .memAddress(memAddress),
        .memWriteData(memWriteData), .memReadData(memReadData)
    );

    // Data memory: DUT writes, bench backdoor pokes, and strobe-overlap monitor.
    always @(posedge clk) begin
        if (MemWrite && memAddress < 32'd32) tbMem[memAddress[4:0]] <= memWriteData;
        else if (bdEn) tbMem[bdIdx] <= bdData;
        if (MemRead && MemWrite) overlapCount <= overlapCount + 1;
    end
    assign memReadData = (memAddress < 32'd32) ? tbMem[memAddress[4:0]] : 32'h0;

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        bdEn = 1'b1; bdIdx = 5'(idx); bdData = val;
        @(posedge clk); #1 bdEn = 1'b0;
        model[idx] = val;
    endtask

    function automatic logic modelErr(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        int size;
        logic legal;
        if (wr) legal = (f3 inside {3'd0, 3'd1, 3'd2});
        else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        size = 1 << (int'(f3) % 4);
        if (int'(a % 32'(size)) != 0) return 1'b1;
        return (a / 32'd4) >= 32'd32;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] word, v;
        int off;
        word = model[int'(a / 32'd4)];
        off  = int'(a % 32'd4);
        v = 32'h0;
        case (f3)
            3'd0, 3'd4: begin
                v = (word >> (8 * off)) & 32'd255;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (word >> (8 * off)) & 32'd65535;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            3'd2: v = word;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic modelStore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [7:0] b [4];
        int idx, off, n;
        idx = int'(a / 32'd4);
        off = int'(a % 32'd4);
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int i = 0; i < 4; i++) b[i] = 8'(model[idx] >> (8 * i));
        for (int i = 0; i < n; i++) b[off + i] = 8'(wd >> (8 * i));
        model[idx] = {b[3], b[2], b[1], b[0]};
    endtask

    task automatic runReq(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic err,
                          output logic [31:0] data, output int nRd, output int nWr,
                          output logic [31:0] strobeAddr, output logic [31:0] lastWData);
        int w;
        lat = 0; err = 1'b0; data = 32'h0; nRd = 0; nWr = 0; strobeAddr = 32'h0; lastWData = 32'h0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; wdata = wd;
        w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; wdata = $urandom;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (MemRead)  begin nRd++; strobeAddr = memAddress; end
            if (MemWrite) begin nWr++; strobeAddr = memAddress; lastWData = memWriteData; end
            if (resp_valid) begin lat = c; err = resp_err; data = rdata; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
        #12;
        checks++;
        if ({req_ready, resp_valid, resp_err, MemRead, MemWrite} !== 5'b10000 ||
            rdata !== 32'h0 || memAddress !== 32'h0 || memWriteData !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b rv=%b err=%b rd=%b wr=%b rdata=%h addr=%h wd=%h",
                     req_ready, resp_valid, resp_err, MemRead, MemWrite, rdata, memAddress, memWriteData);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 32; i++) poke(i, $urandom);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_spec_vectors();
        int lat, nRd, nWr; logic err; logic [31:0] data, sa, lw;
        logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] as  [4] = '{32'h0E, 32'h0E, 32'h0E, 32'h0C};
        logic [31:0] exs [4] = '{32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_8081, 32'h0000_7F01};
        poke(3, 32'h8081_7F01);
        runReq(1'b0, 3'd2, 32'h0C, 32'h0, lat, err, data, nRd, nWr, sa, lw);
        checks++;
        if (data !== 32'h8081_7F01 || err !== 1'b0 || lat != 2 || nRd != 1 || nWr != 0 || sa !== 32'd3) begin
            errors++;
            $display("FAIL lw_vector got data=%h err=%b lat=%0d rd=%0d wr=%0d addr=%0d exp 80817f01/0/2/1/0/3",
                     data, err, lat, nRd, nWr, sa);
        end
        checks++;
        @(negedge clk);
        if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_resp got=%b exp=1", req_ready); end
        for (int i = 0; i < 4; i++) begin
            runReq(1'b0, f3s[i], as[i], 32'h0, lat, err, data, nRd, nWr, sa, lw);
            checks++;
            if (data !== exs[i] || err !== 1'b0 || lat != 2) begin
                errors++;
                $display("FAIL subword_load_%0d got data=%h err=%b lat=%0d exp data=%h err=0 lat=2",
                         i, data, err, lat, exs[i]);
            end
        end
        poke(2, 32'h1122_3344);
        runReq(1'b1, 3'd0, 32'h09, 32'hAAAA_AAEE, lat, err, data, nRd, nWr, sa, lw);
        modelStore(3'd0, 32'h09, 32'hAAAA_AAEE);
        checks++;
        if (lw !== 32'h1122_EE44 || lat != 3 || nRd != 1 || nWr != 1 || err !== 1'b0 || data !== 32'h0) begin
            errors++;
            $display("FAIL sb_vector got wdata=%h lat=%0d rd=%0d wr=%0d err=%b rdata=%h exp 1122ee44/3/1/1/0/0",
                     lw, lat, nRd, nWr, err, data);
        end
        runReq(1'b1, 3'd1, 32'h0A, 32'h0000_BEEF, lat, err, data, nRd, nWr, sa, lw);
        modelStore(3'd1, 32'h0A, 32'h0000_BEEF);
        checks++;
        if (tbMem[2] !== 32'hBEEF_EE44 || lat != 3) begin
            errors++;
            $display("FAIL sh_vector got mem=%h lat=%0d exp mem=beefee44 lat=3", tbMem[2], lat);
        end
    endtask

    task automatic test_errors();
        int lat, nRd, nWr; logic err; logic [31:0] data, sa, lw;
        logic        wrs [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [3] = '{3'd2, 3'd1, 3'd2};
        logic [31:0] as  [3] = '{32'h06, 32'h05, 32'h80};
        for (int i = 0; i < 3; i++) begin
            runReq(wrs[i], f3s[i], as[i], 32'h1234_5678, lat, err, data, nRd, nWr, sa, lw);
            checks++;
            if (err !== 1'b1 || lat != 1 || data !== 32'h0 || nRd != 0 || nWr != 0) begin
                errors++;
                $display("FAIL error_case_%0d got err=%b lat=%0d rdata=%h rd=%0d wr=%0d exp 1/1/0/0/0",
                         i, err, lat, data, nRd, nWr);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int lat, nRd, nWr; logic err; logic [31:0] data, sa, lw;
        poke(7, 32'hCAFE_1234);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; funct3 = 3'd0; addr = 32'h1D; wdata = 32'h0000_0055;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (MemRead !== 1'b1) begin errors++; $display("FAIL midflight_read got=%b exp=1", MemRead); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (MemRead !== 1'b0 || MemWrite !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got rd=%b wr=%b rdy=%b exp 0/0/1", MemRead, MemWrite, req_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tbMem[7] !== model[7] || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midflight_mem got mem=%h rdy=%b exp mem=%h rdy=1", tbMem[7], req_ready, model[7]);
        end
        runReq(1'b0, 3'd2, 32'h1C, 32'h0, lat, err, data, nRd, nWr, sa, lw);
        checks++;
        if (data !== 32'hCAFE_1234 || lat != 2 || err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_lw got data=%h lat=%0d err=%b exp cafe1234/2/0", data, lat, err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] as [3] = '{32'h10, 32'h14, 32'h18};
        int acc = 0, resps = 0, cyc = 0;
        int accCyc [3];
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'd2; addr = as[0];
        while ((acc < 3 || resps < 3) && cyc < 60) begin
            if (resp_valid && resps < 3) begin
                checks++;
                if (rdata !== modelLoad(3'd2, as[resps]) || resp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_data_%0d got=%h exp=%h", resps, rdata, modelLoad(3'd2, as[resps]));
                end
                resps++;
            end
            if (req_valid && req_ready) begin
                accCyc[acc] = cyc;
                acc++;
                @(posedge clk); #1;
                if (acc < 3) addr = as[acc];
                else req_valid = 1'b0;
            end
            @(negedge clk); cyc++;
        end
        checks++;
        if (acc != 3 || resps != 3 || overlapCount != 0) begin
            errors++;
            $display("FAIL b2b_counts got acc=%0d resp=%0d overlap=%0d exp 3/3/0", acc, resps, overlapCount);
        end
        checks++;
        if (acc == 3 && (accCyc[1] - accCyc[0] != 3 || accCyc[2] - accCyc[1] != 3)) begin
            errors++;
            $display("FAIL b2b_spacing got %0d,%0d exp 3,3", accCyc[1] - accCyc[0], accCyc[2] - accCyc[1]);
        end
    endtask

    task automatic test_random();
        int lat, nRd, nWr, expLat, idx; logic err, expErr, wr; logic [2:0] f3;
        logic [31:0] data, sa, lw, a, wd, expData;
        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 34)) * 32'd4;
            if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            wd = $urandom;
            expErr  = modelErr(wr, f3, a);
            expData = (expErr || wr) ? 32'h0 : modelLoad(f3, a);
            expLat  = expErr ? 1 : (!wr || f3 == 3'd2) ? 2 : 3;
            runReq(wr, f3, a, wd, lat, err, data, nRd, nWr, sa, lw);
            checks++;
            if (err !== expErr || data !== expData || lat != expLat) begin
                errors++;
                $display("FAIL rand_%0d wr=%b f3=%0d a=%h got err=%b data=%h lat=%0d exp err=%b data=%h lat=%0d",
                         n, wr, f3, a, err, data, lat, expErr, expData, expLat);
            end
            if (!expErr && wr) begin
                modelStore(f3, a, wd);
                idx = int'(a / 32'd4);
                checks++;
                if (tbMem[idx] !== model[idx] || nWr != 1 || nRd != ((f3 == 3'd2) ? 0 : 1)) begin
                    errors++;
                    $display("FAIL rand_store_%0d got mem=%h rd=%0d wr=%0d exp mem=%h",
                             n, tbMem[idx], nRd, nWr, model[idx]);
                end
            end
        end
        checks++;
        if (overlapCount != 0) begin errors++; $display("FAIL strobe_overlap got=%0d exp=0", overlapCount); end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_errors();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
